// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: operation encoding
// and status flag bit positions within the 4-bit status word.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_ADC = 4'd1,
      OP_SUB = 4'd2,
      OP_SBC = 4'd3,
      OP_AND = 4'd4,
      OP_OR  = 4'd5,
      OP_XOR = 4'd6,
      OP_NOT = 4'd7,
      OP_INC = 4'd8,
      OP_DEC = 4'd9,
      OP_CMP = 4'd10,
      OP_SHL = 4'd11,
      OP_SHR = 4'd12,
      OP_ASR = 4'd13,
      OP_ROL = 4'd14,
      OP_ROR = 4'd15
   } op_e;

   localparam int FLG_C = 0;
   localparam int FLG_Z = 1;
   localparam int FLG_N = 2;
   localparam int FLG_V = 3;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum, carry (or borrow when sub=1), overflow.
// Ports: x, y operands; ci carry/borrow-in; sub selects x-y; sum, c, v.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             ci,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             c,
   output logic             v
);

   logic [WIDTH-1:0] ye;
   logic [WIDTH:0]   full;

   // Subtract as x + ~y + ~borrow; carry-out inverted is the borrow.
   assign ye   = sub ? ~y : y;
   assign full = {1'b0, x} + {1'b0, ye}
               + {{WIDTH{1'b0}}, ci ^ sub};
   assign sum  = full[WIDTH-1:0];
   assign c    = full[WIDTH] ^ sub;
   assign v    = (x[WIDTH-1] == ye[WIDTH-1])
               && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/alu_core.sv
// Registered 16-op ALU: result and C/Z/N/V one clock after sampling.
// Ports: clk, rst_n (async low); a, b, s_in, op in; s_c/s_z/s_n/s_v,
// result out. Define ALU_SAT_EN for signed saturation of ADD..SBC.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s_in,
   input  logic [3:0]       op,
   output logic             s_c,
   output logic             s_z,
   output logic             s_n,
   output logic             s_v,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] ONE =
      {{(WIDTH-1){1'b0}}, 1'b1};

   op_e              opc;
   logic             cin;
   logic [WIDTH-1:0] as_y;
   logic             as_ci;
   logic             as_sub;
   logic [WIDTH-1:0] as_sum;
   logic             as_c;
   logic             as_v;

   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] zn_src;
   logic             c_d;
   logic             v_d;

   logic             unused_flags;

   assign opc          = op_e'(op);
   assign cin          = s_in[FLG_C];
   assign unused_flags = ^{s_in[FLG_Z], s_in[FLG_N]};

   always_comb begin
      as_y   = b;
      as_ci  = 1'b0;
      as_sub = 1'b0;
      unique case (opc)
         OP_ADC: as_ci = cin;
         OP_SUB: as_sub = 1'b1;
         OP_SBC: begin
            as_sub = 1'b1;
            as_ci  = cin;
         end
         OP_INC: as_y = ONE;
         OP_DEC: begin
            as_y   = ONE;
            as_sub = 1'b1;
         end
         OP_CMP: as_sub = 1'b1;
         default: ;
      endcase
   end

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .x   (a),
      .y   (as_y),
      .ci  (as_ci),
      .sub (as_sub),
      .sum (as_sum),
      .c   (as_c),
      .v   (as_v)
   );

   always_comb begin
      res_d = as_sum;
      c_d   = as_c;
      v_d   = as_v;
      unique case (opc)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
`ifdef ALU_SAT_EN
            // Overflow direction follows the sign of a.
            if (as_v)
               res_d = a[WIDTH-1]
                     ? {1'b1, {(WIDTH-1){1'b0}}}
                     : {1'b0, {(WIDTH-1){1'b1}}};
`endif
         end
         OP_INC, OP_DEC: ;
         OP_CMP: res_d = a;
         OP_AND: begin
            res_d = a & b;
            c_d   = cin;
            v_d   = s_in[FLG_V];
         end
         OP_OR: begin
            res_d = a | b;
            c_d   = cin;
            v_d   = s_in[FLG_V];
         end
         OP_XOR: begin
            res_d = a ^ b;
            c_d   = cin;
            v_d   = s_in[FLG_V];
         end
         OP_NOT: begin
            res_d = ~a;
            c_d   = cin;
            v_d   = s_in[FLG_V];
         end
         OP_SHL: begin
            res_d = {a[WIDTH-2:0], 1'b0};
            c_d   = a[WIDTH-1];
         end
         OP_SHR: begin
            res_d = {1'b0, a[WIDTH-1:1]};
            c_d   = a[0];
         end
         OP_ASR: begin
            res_d = {a[WIDTH-1], a[WIDTH-1:1]};
            c_d   = a[0];
         end
         OP_ROL: begin
            res_d = {a[WIDTH-2:0], cin};
            c_d   = a[WIDTH-1];
         end
         OP_ROR: begin
            res_d = {cin, a[WIDTH-1:1]};
            c_d   = a[0];
         end
         default: ;
      endcase
      if (opc inside {OP_SHL, OP_SHR, OP_ASR,
                      OP_ROL, OP_ROR})
         v_d = res_d[WIDTH-1] ^ a[WIDTH-1];
   end

   // CMP keeps a as result but reports Z/N of the difference.
   assign zn_src = (opc == OP_CMP) ? as_sum : res_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         s_c    <= 1'b0;
         s_z    <= 1'b0;
         s_n    <= 1'b0;
         s_v    <= 1'b0;
      end else begin
         result <= res_d;
         s_c    <= c_d;
         s_z    <= (zn_src == '0);
         s_n    <= zn_src[WIDTH-1];
         s_v    <= v_d;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Directed table-driven bench for alu_core plus reset/latency sequences.
// Flags are compared as {V,N,Z,C}; ALU_SAT_EN selects saturating expects.
module tb_alu_core;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] s_in;
   logic [3:0] op;
   logic       s_c, s_z, s_n, s_v;
   logic [7:0] result;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] s_in;
      logic [7:0] res;
      logic [3:0] flg;
   } vec_t;

   vec_t vecs[$];

   alu_core #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .s_in   (s_in),
      .op     (op),
      .s_c    (s_c),
      .s_z    (s_z),
      .s_n    (s_n),
      .s_v    (s_v),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [7:0] er,
                        input logic [3:0] ef);
      logic [3:0] f;
      f = {s_v, s_n, s_z, s_c};
      total++;
      if (result !== er || f !== ef) begin
         bad++;
         $display("FAIL %s: result=%h flags=%b want result=%h flags=%b",
                  name, result, f, er, ef);
      end
   endtask

   task automatic drive(input vec_t v);
      op   = v.op;
      a    = v.a;
      b    = v.b;
      s_in = v.s_in;
   endtask

   function automatic vec_t mk(input string n, input logic [3:0] o,
                               input logic [7:0] x, input logic [7:0] y,
                               input logic [3:0] s, input logic [7:0] r,
                               input logic [3:0] f);
      vec_t v;
      v.name = n; v.op = o; v.a = x; v.b = y;
      v.s_in = s; v.res = r; v.flg = f;
      return v;
   endfunction

   initial begin
      vecs.push_back(mk("cmp_00_01", 10, 8'h00, 8'h01, 4'h0, 8'h00, 4'b0101));
      vecs.push_back(mk("add_dc_64",  0, 8'hDC, 8'h64, 4'h0, 8'h40, 4'b0001));
      vecs.push_back(mk("sub_88_c8",  2, 8'h88, 8'hC8, 4'h0, 8'hC0, 4'b0101));
`ifdef ALU_SAT_EN
      vecs.push_back(mk("add_7f_01",  0, 8'h7F, 8'h01, 4'h0, 8'h7F, 4'b1000));
      vecs.push_back(mk("add_80_80",  0, 8'h80, 8'h80, 4'h0, 8'h80, 4'b1101));
      vecs.push_back(mk("sub_80_01",  2, 8'h80, 8'h01, 4'h0, 8'h80, 4'b1100));
`else
      vecs.push_back(mk("add_7f_01",  0, 8'h7F, 8'h01, 4'h0, 8'h80, 4'b1100));
      vecs.push_back(mk("add_80_80",  0, 8'h80, 8'h80, 4'h0, 8'h00, 4'b1011));
      vecs.push_back(mk("sub_80_01",  2, 8'h80, 8'h01, 4'h0, 8'h7F, 4'b1000));
`endif
      vecs.push_back(mk("rol_80_c1", 14, 8'h80, 8'h00, 4'h1, 8'h01, 4'b1001));
      vecs.push_back(mk("add_ff_01",  0, 8'hFF, 8'h01, 4'h0, 8'h00, 4'b0011));
      vecs.push_back(mk("sub_00_01",  2, 8'h00, 8'h01, 4'h0, 8'hFF, 4'b0101));
      vecs.push_back(mk("adc_c1",     1, 8'h10, 8'h20, 4'h1, 8'h31, 4'b0000));
      vecs.push_back(mk("add_ign_c",  0, 8'h10, 8'h20, 4'h1, 8'h30, 4'b0000));
      vecs.push_back(mk("sbc_c1",     3, 8'h50, 8'h10, 4'h1, 8'h3F, 4'b0000));
      vecs.push_back(mk("sbc_00_c1",  3, 8'h00, 8'h00, 4'h1, 8'hFF, 4'b0101));
      vecs.push_back(mk("adc_ff_c1",  1, 8'hFF, 8'h00, 4'h1, 8'h00, 4'b0011));
      vecs.push_back(mk("and_pass",   4, 8'hF0, 8'h3C, 4'h9, 8'h30, 4'b1001));
      vecs.push_back(mk("or_zero",    5, 8'h00, 8'h00, 4'h0, 8'h00, 4'b0010));
      vecs.push_back(mk("xor_aa_ff",  6, 8'hAA, 8'hFF, 4'h0, 8'h55, 4'b0000));
      vecs.push_back(mk("not_0f",     7, 8'h0F, 8'h00, 4'h1, 8'hF0, 4'b0101));
      vecs.push_back(mk("inc_7f",     8, 8'h7F, 8'h00, 4'h0, 8'h80, 4'b1100));
      vecs.push_back(mk("inc_ff",     8, 8'hFF, 8'h00, 4'h1, 8'h00, 4'b0011));
      vecs.push_back(mk("dec_80",     9, 8'h80, 8'h00, 4'h0, 8'h7F, 4'b1000));
      vecs.push_back(mk("dec_00",     9, 8'h00, 8'h00, 4'h1, 8'hFF, 4'b0101));
      vecs.push_back(mk("cmp_eq",    10, 8'h05, 8'h05, 4'h0, 8'h05, 4'b0010));
      vecs.push_back(mk("shl_81",    11, 8'h81, 8'h00, 4'h0, 8'h02, 4'b1001));
      vecs.push_back(mk("shr_81",    12, 8'h81, 8'h00, 4'h0, 8'h40, 4'b1001));
      vecs.push_back(mk("asr_81",    13, 8'h81, 8'h00, 4'h0, 8'hC0, 4'b0101));
      vecs.push_back(mk("ror_c1",    15, 8'h01, 8'h00, 4'h1, 8'h80, 4'b1101));
      vecs.push_back(mk("ror_c0",    15, 8'h01, 8'h00, 4'h0, 8'h00, 4'b0011));

      rst_n = 1'b0;
      drive(vecs[1]);
      #1 check("rst_async", 8'h00, 4'b0000);
      repeat (3) @(posedge clk);
      #1 check("rst_held", 8'h00, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_release", 8'h00, 4'b0000);

      // Back-to-back: a new vector every cycle, checked after its edge.
      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1 check(vecs[i].name, vecs[i].res, vecs[i].flg);
         @(negedge clk);
      end

      // Latency: new inputs are not visible before the next edge.
      drive(vecs[1]);
      @(posedge clk);
      #1 check("lat_first", 8'h40, 4'b0001);
      @(negedge clk);
      drive(vecs[2]);
      #1 check("lat_hold", 8'h40, 4'b0001);
      @(posedge clk);
      #1 check("lat_next", 8'hC0, 4'b0101);

      // Mid-stream reset clears outputs at once and drops the sample.
      @(negedge clk);
      drive(vecs[7]);
      #2 rst_n = 1'b0;
      #1 check("rst_mid", 8'h00, 4'b0000);
      @(posedge clk);
      #1 check("rst_mid_edge", 8'h00, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      drive(vecs[0]);
      @(posedge clk);
      #1 check("rst_resume", 8'h00, 4'b0101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
